disp_fetch: RTL and testbench

- Frame-fetch DMA stage directly downstream of the display control registers.
- Consumes DISPON, DISPADDR and the panel VSYNC, and reads one frame per VSYNC from VRAM over an AXI4 read channel.
- Pushes pixel words into the display line FIFO, which feeds the pixel output stage. That FIFO's over/underrun flags return to the control registers.

---
 rtl/disp_fetch.sv | 183 ++++++++++++++++++
 tb/tb_disp_fetch.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_fetch.sv
// Frame-fetch DMA: on each panel VSYNC reads one frame from VRAM over AXI4
// and streams the beats into the display line FIFO, one burst in flight at a time.
//
// state   | meaning
// IDLE    | display disabled, nothing fetched
// WAIT_VS | enabled, waiting for the start of the next frame
// ADDR    | waiting for FIFO room, then presenting the burst address
// DATA    | accepting read beats of the current burst into the FIFO
module disp_fetch #(
    parameter int BURST_LEN    = 16,
    parameter int FRAME_BURSTS = 19200,
    parameter int FIFO_AW      = 10
) (
    input  logic               ACLK,
    input  logic               ARST,
    input  logic               DISPON,
    input  logic [28:0]        DISPADDR,
    input  logic               DSP_VSYNC_X,
    output logic [31:0]        ARADDR,
    output logic [7:0]         ARLEN,
    output logic [2:0]         ARSIZE,
    output logic [1:0]         ARBURST,
    output logic               ARVALID,
    input  logic               ARREADY,
    input  logic [31:0]        RDATA,
    input  logic               RLAST,
    input  logic               RVALID,
    output logic               RREADY,
    input  logic [1:0]         RRESP,
    output logic               FIFO_WR,
    output logic [31:0]        FIFO_WDATA,
    input  logic [FIFO_AW:0]   FIFO_FREE,
    output logic               FETCH_BUSY
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT_VS = 2'd1;
    localparam logic [1:0] S_ADDR    = 2'd2;
    localparam logic [1:0] S_DATA    = 2'd3;

    localparam int CW = $clog2(FRAME_BURSTS + 1);
    localparam logic [CW-1:0]    LAST_CNT = CW'(FRAME_BURSTS - 1);
    localparam logic [FIFO_AW:0] FREE_MIN = (FIFO_AW + 1)'(BURST_LEN);

    logic [1:0]    state;
    logic          vs_meta;
    logic          vs_sync;
    logic          vs_hist;
    logic          vs_start;
    logic [CW-1:0] burst_cnt;
    logic          restart_pend;
    logic [31:0]   base_addr;
    logic [31:0]   next_addr;
    logic          beat;
    logic          last_beat;

    // RRESP is deliberately ignored and the low address bits are dropped by alignment.
    logic unused_bits;
    assign unused_bits = ^{RRESP, DISPADDR[5:0]};

    assign ARLEN   = 8'(BURST_LEN - 1);
    assign ARSIZE  = 3'b010;
    assign ARBURST = 2'b01;

    assign base_addr = {3'b000, DISPADDR[28:6], 6'b000000};
    assign next_addr = {3'b000, ARADDR[28:0] + 29'd64};
    assign beat      = RVALID && RREADY;
    assign last_beat = beat && RLAST;

    // Pin idles high, so the flops reset high to avoid a false frame start.
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            vs_meta <= 1'b1;
            vs_sync <= 1'b1;
            vs_hist <= 1'b1;
        end else begin
            vs_meta <= DSP_VSYNC_X;
            vs_sync <= vs_meta;
            vs_hist <= vs_sync;
        end
    end

    assign vs_start = vs_hist && !vs_sync;

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            FIFO_WR    <= 1'b0;
            FIFO_WDATA <= 32'd0;
        end else begin
            FIFO_WR <= beat;
            if (beat) begin
                FIFO_WDATA <= RDATA;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            state        <= S_IDLE;
            ARADDR       <= 32'd0;
            ARVALID      <= 1'b0;
            RREADY       <= 1'b0;
            FETCH_BUSY   <= 1'b0;
            burst_cnt    <= '0;
            restart_pend <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    restart_pend <= 1'b0;
                    if (DISPON) begin
                        state <= S_WAIT_VS;
                    end
                end

                S_WAIT_VS: begin
                    if (!DISPON) begin
                        state <= S_IDLE;
                    end else if (vs_start) begin
                        ARADDR     <= base_addr;
                        burst_cnt  <= '0;
                        FETCH_BUSY <= 1'b1;
                        state      <= S_ADDR;
                    end
                end

                S_ADDR: begin
                    if (ARVALID) begin
                        // Address is committed; a late frame start can only be deferred.
                        if (vs_start) begin
                            restart_pend <= 1'b1;
                        end
                        if (ARREADY) begin
                            ARVALID <= 1'b0;
                            RREADY  <= 1'b1;
                            state   <= S_DATA;
                        end
                    end else if (!DISPON) begin
                        FETCH_BUSY   <= 1'b0;
                        restart_pend <= 1'b0;
                        state        <= S_IDLE;
                    end else if (vs_start) begin
                        ARADDR       <= base_addr;
                        burst_cnt    <= '0;
                        restart_pend <= 1'b0;
                    end else if (FIFO_FREE >= FREE_MIN) begin
                        ARVALID <= 1'b1;
                    end
                end

                S_DATA: begin
                    if (vs_start) begin
                        restart_pend <= 1'b1;
                    end
                    if (last_beat) begin
                        RREADY    <= 1'b0;
                        ARADDR    <= next_addr;
                        burst_cnt <= burst_cnt + CW'(1);
                        if (!DISPON) begin
                            FETCH_BUSY   <= 1'b0;
                            restart_pend <= 1'b0;
                            state        <= S_IDLE;
                        end else if (restart_pend || vs_start) begin
                            ARADDR       <= base_addr;
                            burst_cnt    <= '0;
                            restart_pend <= 1'b0;
                            state        <= S_ADDR;
                        end else if (burst_cnt == LAST_CNT) begin
                            FETCH_BUSY <= 1'b0;
                            state      <= S_WAIT_VS;
                        end else begin
                            state <= S_ADDR;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_disp_fetch.sv
// Scoreboard bench for disp_fetch: directed frames against a simple AXI read slave,
// expected addresses and FIFO words queued by the stimulus and popped by a monitor.
module tb_disp_fetch;

    localparam int FB = 4;

    logic        ACLK = 1'b0;
    logic        ARST;
    logic        DISPON;
    logic [28:0] DISPADDR;
    logic        DSP_VSYNC_X;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic [1:0]  RRESP;
    logic        FIFO_WR;
    logic [31:0] FIFO_WDATA;
    logic [10:0] FIFO_FREE;
    logic        FETCH_BUSY;

    disp_fetch #(.BURST_LEN(16), .FRAME_BURSTS(FB), .FIFO_AW(10)) dut (
        .ACLK(ACLK), .ARST(ARST), .DISPON(DISPON), .DISPADDR(DISPADDR),
        .DSP_VSYNC_X(DSP_VSYNC_X), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY), .RDATA(RDATA),
        .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY), .RRESP(RRESP),
        .FIFO_WR(FIFO_WR), .FIFO_WDATA(FIFO_WDATA), .FIFO_FREE(FIFO_FREE),
        .FETCH_BUSY(FETCH_BUSY)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int ar_count = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a, input int i);
        return (a + 32'(i * 4)) ^ 32'hA500_0000;
    endfunction

    task automatic push_burst(input logic [31:0] a);
        exp_addr.push_back(a);
        for (int i = 0; i < 16; i++) exp_data.push_back(pat(a, i));
    endtask

    // Monitor: address handshakes, FIFO writes and address stability while stalled.
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    always @(negedge ACLK) begin
        if (ARST) begin
            prev_wait = 1'b0;
        end else begin
            if (prev_wait) begin
                chk("arvalid_hold", {31'd0, ARVALID}, 32'd1);
                chk("araddr_hold", ARADDR, prev_addr);
            end
            if (ARVALID && ARREADY) begin
                ar_count++;
                if (exp_addr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ar_unexpected: got 0x%08h expected no address", ARADDR);
                end else begin
                    chk("araddr", ARADDR, exp_addr.pop_front());
                end
            end
            if (FIFO_WR) begin
                wr_count++;
                if (exp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected: got 0x%08h expected no write", FIFO_WDATA);
                end else begin
                    chk("fifo_wdata", FIFO_WDATA, exp_data.pop_front());
                end
            end
            prev_wait = ARVALID && !ARREADY;
            prev_addr = ARADDR;
        end
    end

    // AXI read slave: one burst at a time, data pattern derived from the accepted address.
    int          s_beat = 0;
    int          s_bursts = 0;
    logic        s_busy = 1'b0;
    logic [31:0] s_addr = 32'd0;
    initial begin
        logic        ar_hs;
        logic        r_hs;
        logic [31:0] a;
        RVALID = 1'b0;
        RLAST  = 1'b0;
        RDATA  = 32'd0;
        forever begin
            @(negedge ACLK);
            ar_hs = ARVALID && ARREADY && !ARST;
            r_hs  = RVALID && RREADY && !ARST;
            a     = ARADDR;
            @(posedge ACLK);
            #1;
            if (ARST) begin
                RVALID = 1'b0;
                RLAST  = 1'b0;
                s_busy = 1'b0;
                s_beat = 0;
            end else begin
                if (r_hs) begin
                    s_beat++;
                    if (s_beat == 16) begin
                        RVALID = 1'b0;
                        RLAST  = 1'b0;
                        s_busy = 1'b0;
                        s_beat = 0;
                        s_bursts++;
                    end else begin
                        RDATA = pat(s_addr, s_beat);
                        RLAST = (s_beat == 15);
                    end
                end
                if (ar_hs) begin
                    s_addr = a;
                    s_busy = 1'b1;
                    s_beat = 0;
                    RVALID = 1'b1;
                    RDATA  = pat(a, 0);
                    RLAST  = 1'b0;
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge ACLK);
        #2;
    endtask

    task automatic vsync_pulse();
        DSP_VSYNC_X = 1'b0;
        cycles(4);
        DSP_VSYNC_X = 1'b1;
    endtask

    task automatic wait_busy(input string name, input logic val, input int budget);
        int n = 0;
        while (FETCH_BUSY !== val && n < budget) begin
            cycles(1);
            n++;
        end
        chk(name, {31'd0, FETCH_BUSY}, {31'd0, val});
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_addr.size() != 0 || exp_data.size() != 0) && n < budget) begin
            cycles(1);
            n++;
        end
        checks++;
        if (exp_addr.size() != 0 || exp_data.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d addr and %0d data pending, expected 0 and 0", name,
                     exp_addr.size(), exp_data.size());
        end
        cycles(3);
    endtask

    task automatic wait_beat(input string name, input int burst, input int beat_no, input int budget);
        int n = 0;
        while (!(s_bursts == burst && s_beat >= beat_no) && n < budget) begin
            cycles(1);
            n++;
        end
        checks++;
        if (!(s_bursts == burst && s_beat >= beat_no)) begin
            errors++;
            $display("FAIL %s: got burst %0d beat %0d, expected burst %0d beat %0d", name,
                     s_bursts, s_beat, burst, beat_no);
        end
    endtask

    task automatic count_arvalid(input string name, input int n);
        int hi = 0;
        repeat (n) begin
            @(negedge ACLK);
            if (ARVALID) hi++;
        end
        chk(name, 32'(hi), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        int a0;
        int b0;
        ARST = 1'b1;
        DISPON = 1'b0;
        DISPADDR = 29'd0;
        DSP_VSYNC_X = 1'b1;
        ARREADY = 1'b1;
        RRESP = 2'b10;
        FIFO_FREE = 11'd1023;
        cycles(3);
        chk("rst_arvalid", {31'd0, ARVALID}, 32'd0);
        chk("rst_rready", {31'd0, RREADY}, 32'd0);
        chk("rst_fifo_wr", {31'd0, FIFO_WR}, 32'd0);
        chk("rst_wdata", FIFO_WDATA, 32'd0);
        chk("rst_araddr", ARADDR, 32'd0);
        chk("rst_busy", {31'd0, FETCH_BUSY}, 32'd0);
        chk("arlen", {24'd0, ARLEN}, 32'd15);
        chk("arsize_arburst", {27'd0, ARSIZE, ARBURST}, 32'b01001);
        ARST = 1'b0;
        cycles(2);

        // Full frame of four bursts.
        DISPADDR = 29'h0100_0040;
        DISPON = 1'b1;
        cycles(2);
        push_burst(32'h0100_0040);
        push_burst(32'h0100_0080);
        push_burst(32'h0100_00C0);
        push_burst(32'h0100_0100);
        w0 = wr_count;
        vsync_pulse();
        wait_busy("frame1_busy", 1'b1, 20);
        wait_drain("frame1_drain", 400);
        chk("frame1_wr_count", 32'(wr_count - w0), 32'd64);
        chk("frame1_busy_done", {31'd0, FETCH_BUSY}, 32'd0);
        count_arvalid("frame1_no_extra_ar", 20);

        // FIFO back-pressure, stalled ARREADY and low-bit masking.
        DISPADDR = 29'h0000_007F;
        FIFO_FREE = 11'd15;
        ARREADY = 1'b0;
        push_burst(32'h0000_0040);
        push_burst(32'h0000_0080);
        push_burst(32'h0000_00C0);
        push_burst(32'h0000_0100);
        vsync_pulse();
        wait_busy("frame2_busy", 1'b1, 20);
        count_arvalid("arvalid_while_fifo_low", 20);
        @(posedge ACLK);
        #2;
        FIFO_FREE = 11'd16;
        @(negedge ACLK);
        chk("arvalid_same_cycle", {31'd0, ARVALID}, 32'd0);
        @(negedge ACLK);
        chk("arvalid_next_cycle", {31'd0, ARVALID}, 32'd1);
        chk("araddr_masked", ARADDR, 32'h0000_0040);
        a0 = ar_count;
        repeat (10) @(negedge ACLK);
        chk("ar_stalled_count", 32'(ar_count - a0), 32'd0);
        @(posedge ACLK);
        #2;
        ARREADY = 1'b1;
        cycles(3);
        chk("ar_handshake_once", 32'(ar_count - a0), 32'd1);
        FIFO_FREE = 11'd1023;
        wait_drain("frame2_drain", 400);
        chk("frame2_busy_done", {31'd0, FETCH_BUSY}, 32'd0);

        // Display disabled mid-burst: burst drains, then nothing more.
        DISPADDR = 29'h0100_0040;
        push_burst(32'h0100_0040);
        push_burst(32'h0100_0080);
        w0 = wr_count;
        b0 = s_bursts;
        vsync_pulse();
        wait_beat("dispon_drop_point", b0 + 1, 5, 200);
        DISPON = 1'b0;
        wait_drain("dispon_drop_drain", 200);
        chk("dispon_drop_wr_count", 32'(wr_count - w0), 32'd32);
        count_arvalid("dispon_drop_no_ar", 30);
        chk("dispon_drop_busy", {31'd0, FETCH_BUSY}, 32'd0);

        // Late VSYNC during burst 2 restarts the frame at the new base.
        DISPADDR = 29'h0100_0040;
        DISPON = 1'b1;
        cycles(2);
        push_burst(32'h0100_0040);
        push_burst(32'h0100_0080);
        push_burst(32'h0200_0000);
        push_burst(32'h0200_0040);
        push_burst(32'h0200_0080);
        push_burst(32'h0200_00C0);
        w0 = wr_count;
        b0 = s_bursts;
        vsync_pulse();
        wait_beat("restart_point", b0 + 1, 2, 200);
        DISPADDR = 29'h0200_0000;
        vsync_pulse();
        wait_drain("restart_drain", 600);
        chk("restart_wr_count", 32'(wr_count - w0), 32'd96);
        chk("restart_busy_done", {31'd0, FETCH_BUSY}, 32'd0);

        // Asynchronous reset in the middle of a burst.
        DISPADDR = 29'h0100_0040;
        push_burst(32'h0100_0040);
        b0 = s_bursts;
        vsync_pulse();
        wait_beat("reset_point", b0, 8, 200);
        chk("pre_reset_busy", {31'd0, FETCH_BUSY}, 32'd1);
        @(negedge ACLK);
        #3;
        ARST = 1'b1;
        #1;
        chk("async_arvalid", {31'd0, ARVALID}, 32'd0);
        chk("async_rready", {31'd0, RREADY}, 32'd0);
        chk("async_fifo_wr", {31'd0, FIFO_WR}, 32'd0);
        chk("async_wdata", FIFO_WDATA, 32'd0);
        chk("async_araddr", ARADDR, 32'd0);
        chk("async_busy", {31'd0, FETCH_BUSY}, 32'd0);
        exp_addr.delete();
        exp_data.delete();
        cycles(3);
        ARST = 1'b0;
        cycles(3);
        chk("post_reset_busy", {31'd0, FETCH_BUSY}, 32'd0);
        count_arvalid("post_reset_no_ar", 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
